// File: rtl/pdm_capture_pkg.sv
// Shared types and helpers for the PDM capture sequencer.
// State encoding and signed saturation limits expressed as functions of the PCM width.
package pdm_capture_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAKE   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/pdm_sat_scale.sv
// Combinational arithmetic right shift followed by signed saturation to PCM_W bits.
// Also used with SHIFT=0 to clamp the wide DC-block accumulator.
module pdm_sat_scale
  import pdm_capture_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int PCM_W = 16,
  parameter int SHIFT = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [PCM_W-1:0] dout
);

  // Compare width must hold both the shifted input and the PCM limits.
  localparam int CW = (IN_W > PCM_W) ? IN_W : PCM_W + 1;
  localparam logic signed [CW-1:0] MAX_V = CW'(sat_max(PCM_W));
  localparam logic signed [CW-1:0] MIN_V = CW'(sat_min(PCM_W));

  logic signed [IN_W-1:0] shifted_s;
  logic signed [CW-1:0]   wide_s;

  // Shift, widen with sign, then clamp into the PCM range.
  always_comb begin
    shifted_s = din >>> SHIFT;
    wide_s    = CW'(shifted_s);
    if (wide_s > MAX_V) begin
      dout = MAX_V[PCM_W-1:0];
    end else if (wide_s < MIN_V) begin
      dout = MIN_V[PCM_W-1:0];
    end else begin
      dout = wide_s[PCM_W-1:0];
    end
  end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// PDM capture sequencer: mic wake-up, decimator flush/settle, scaled PCM output with overflow flag.
// Optional DC-block stage enabled by defining PDM_CAPTURE_CTRL_DC_BLOCK_EN.
module pdm_capture_ctrl
  import pdm_capture_pkg::*;
#(
  parameter int IN_W           = 32,
  parameter int PCM_W          = 16,
  parameter int SHIFT          = 16,
  parameter int WAKE_CYCLES    = 1_000_000,
  parameter int SETTLE_SAMPLES = 8,
  parameter int DC_K           = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  output logic                    mic_clk_en,
  output logic                    dec_flush,
  input  logic signed [IN_W-1:0]  pcm_in_data,
  input  logic                    pcm_in_valid,
  output logic signed [PCM_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overflow,
  input  logic                    clr_overflow
);

  localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int SCW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [WCW-1:0] WAKE_LAST   = WCW'(WAKE_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_SAMPLES - 1);

  state_t                   state_r;
  logic [WCW-1:0]           wake_cnt_r;
  logic [SCW-1:0]           settle_cnt_r;
  logic                     mic_clk_en_r;
  logic                     dec_flush_r;
  logic                     busy_r;
  logic signed [PCM_W-1:0]  out_data_r;
  logic                     out_valid_r;
  logic                     overflow_r;

  logic                     accept_s;
  logic                     load_s;
  logic                     drop_s;
  logic                     settle_done_s;
  logic signed [PCM_W-1:0]  sat_s;
  logic signed [PCM_W-1:0]  sample_s;

  pdm_sat_scale #(
    .IN_W  (IN_W),
    .PCM_W (PCM_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .din  (pcm_in_data),
    .dout (sat_s)
  );

  // Handshake qualifiers; a stop cycle in RUN takes no new sample.
  always_comb begin
    accept_s      = out_valid_r && out_ready;
    load_s        = (state_r == RUN) && pcm_in_valid && !stop && !(out_valid_r && !out_ready);
    drop_s        = (state_r == RUN) && pcm_in_valid && !stop && out_valid_r && !out_ready;
    settle_done_s = (state_r == SETTLE) && pcm_in_valid && !stop && (settle_cnt_r == SETTLE_LAST);
  end

`ifdef PDM_CAPTURE_CTRL_DC_BLOCK_EN
  localparam int DW = PCM_W + DC_K + 2;

  logic signed [PCM_W-1:0] x_prev_r;
  logic signed [PCM_W-1:0] y_prev_r;
  logic signed [DW-1:0]    dc_sum_s;

  // First-order high-pass: y = x - x_prev + y_prev - y_prev/2^DC_K.
  always_comb begin
    dc_sum_s = DW'(sat_s) - DW'(x_prev_r) + DW'(y_prev_r) - (DW'(y_prev_r) >>> DC_K);
  end

  pdm_sat_scale #(
    .IN_W  (DW),
    .PCM_W (PCM_W),
    .SHIFT (0)
  ) u_dc_sat (
    .din  (dc_sum_s),
    .dout (sample_s)
  );

  // Filter history: cleared on RUN entry, advanced only by samples that reach the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_prev_r <= '0;
      y_prev_r <= '0;
    end else if (settle_done_s) begin
      x_prev_r <= '0;
      y_prev_r <= '0;
    end else if (load_s) begin
      x_prev_r <= sat_s;
      y_prev_r <= sample_s;
    end
  end
`else
  assign sample_s = sat_s;
`endif

  // Sequencer FSM with registered clock-enable, flush and busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      wake_cnt_r   <= '0;
      settle_cnt_r <= '0;
      mic_clk_en_r <= 1'b0;
      dec_flush_r  <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !stop) begin
            state_r      <= WAKE;
            wake_cnt_r   <= '0;
            mic_clk_en_r <= 1'b1;
            dec_flush_r  <= 1'b1;
            busy_r       <= 1'b1;
          end
        end
        WAKE: begin
          if (stop) begin
            state_r      <= IDLE;
            mic_clk_en_r <= 1'b0;
            dec_flush_r  <= 1'b1;
            busy_r       <= 1'b0;
          end else if (wake_cnt_r == WAKE_LAST) begin
            state_r      <= SETTLE;
            settle_cnt_r <= '0;
            dec_flush_r  <= 1'b0;
          end else begin
            wake_cnt_r <= wake_cnt_r + WCW'(1);
          end
        end
        SETTLE: begin
          if (stop) begin
            state_r      <= IDLE;
            mic_clk_en_r <= 1'b0;
            dec_flush_r  <= 1'b1;
            busy_r       <= 1'b0;
          end else if (settle_done_s) begin
            state_r <= RUN;
          end else if (pcm_in_valid) begin
            settle_cnt_r <= settle_cnt_r + SCW'(1);
          end
        end
        RUN: begin
          if (stop) begin
            state_r      <= (out_valid_r && !out_ready) ? DRAIN : IDLE;
            mic_clk_en_r <= 1'b0;
            dec_flush_r  <= 1'b1;
            busy_r       <= out_valid_r && !out_ready;
          end
        end
        DRAIN: begin
          if (accept_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          mic_clk_en_r <= 1'b0;
          dec_flush_r  <= 1'b1;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register and sticky overflow; a set beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (load_s) begin
        out_data_r  <= sample_s;
        out_valid_r <= 1'b1;
      end else if (accept_s) begin
        out_valid_r <= 1'b0;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign mic_clk_en = mic_clk_en_r;
  assign dec_flush  = dec_flush_r;
  assign busy       = busy_r;
  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Scoreboard bench for pdm_capture_ctrl: stimulus pushes expected PCM words, a monitor pops on each handshake.
// Honours PDM_CAPTURE_CTRL_DC_BLOCK_EN by passing expectations through a DC-block reference.
module tb_pdm_capture_ctrl;

  localparam int IN_W           = 32;
  localparam int PCM_W          = 16;
  localparam int SHIFT          = 16;
  localparam int WAKE_CYCLES    = 20;
  localparam int SETTLE_SAMPLES = 4;
  localparam int DC_K           = 4;

  logic        clk          = 1'b0;
  logic        rst          = 1'b0;
  logic        start        = 1'b0;
  logic        stop         = 1'b0;
  logic        pcm_in_valid = 1'b0;
  logic        out_ready    = 1'b0;
  logic        clr_overflow = 1'b0;
  logic [31:0] pcm_in_data  = 32'h0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        mic_clk_en;
  logic        dec_flush;
  logic        busy;
  logic        overflow;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic [15:0] last_out     = 16'h0;
  logic [15:0] last_pushed  = 16'h0;
  logic signed [15:0] dc_x  = 16'sh0;
  logic signed [15:0] dc_y  = 16'sh0;

  pdm_capture_ctrl #(
    .IN_W           (IN_W),
    .PCM_W          (PCM_W),
    .SHIFT          (SHIFT),
    .WAKE_CYCLES    (WAKE_CYCLES),
    .SETTLE_SAMPLES (SETTLE_SAMPLES),
    .DC_K           (DC_K)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .mic_clk_en   (mic_clk_en),
    .dec_flush    (dec_flush),
    .pcm_in_data  (pcm_in_data),
    .pcm_in_valid (pcm_in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    pcm_in_data  = d;
    pcm_in_valid = 1'b1;
    tick();
    pcm_in_valid = 1'b0;
  endtask

  // Hand-computed saturated value in, expected output word queued.
  task automatic push_exp(input logic [15:0] sat);
`ifdef PDM_CAPTURE_CTRL_DC_BLOCK_EN
    logic signed [31:0] acc;
    acc = 32'(signed'(sat)) - 32'(dc_x) + 32'(dc_y) - (32'(dc_y) >>> DC_K);
    if (acc > 32'sd32767) acc = 32'sd32767;
    else if (acc < -32'sd32768) acc = -32'sd32768;
    dc_x = signed'(sat);
    dc_y = acc[15:0];
    last_pushed = acc[15:0];
`else
    last_pushed = sat;
`endif
    exp_q.push_back(last_pushed);
  endtask

  task automatic enter_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wake_mic_en", 32'(mic_clk_en), 32'd1);
    check("wake_busy", 32'(busy), 32'd1);
    repeat (WAKE_CYCLES - 1) tick();
    check("wake_flush_held", 32'(dec_flush), 32'd1);
    tick();
    check("settle_flush_low", 32'(dec_flush), 32'd0);
    for (int i = 0; i < SETTLE_SAMPLES; i++) begin
      send(32'h1234_5678 + 32'(i));
      tick();
      check("settle_discard", 32'(out_valid), 32'd0);
    end
    dc_x = 16'sh0;
    dc_y = 16'sh0;
  endtask

  // Monitor: every accepted output word is compared with the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_exp));
        last_out = out_data;
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_dec_flush", 32'(dec_flush), 32'd1);
    check("rst_mic_en", 32'(mic_clk_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // start and stop together in IDLE do nothing
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_idle", 32'(busy), 32'd0);

    // 1: wake/settle timing and first-sample latency
    enter_run();
    out_ready = 1'b0;
    push_exp(16'h0001);
    send(32'h0001_2345);
    check("latency1", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("valid_cleared", 32'(out_valid), 32'd0);

    // 2: scaling, back-to-back with out_ready high
    push_exp(16'h8000); send(32'h8000_0000);
    push_exp(16'h7FFF); send(32'h7FFF_FFFF);
    push_exp(16'hFFFF); send(32'hFFFF_0000);
    push_exp(16'h0000); send(32'h0000_FFFF);
    tick();
    tick();

    // 3: overflow on back-pressure, clear, and coincident accept
    out_ready = 1'b0;
    push_exp(16'h0003);
    send(32'h0003_0000);
    tick();
    send(32'h0004_0000);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_hold_data", 32'(out_data), 32'(last_pushed));
    check("ovf_hold_valid", 32'(out_valid), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    push_exp(16'h0004);
    send(32'h0004_0000);
    check("coincident_no_ovf", 32'(overflow), 32'd0);
    check("coincident_data", 32'(out_data), 32'(last_pushed));
    tick();
    out_ready = 1'b0;
    push_exp(16'h0006);
    send(32'h0006_0000);
    clr_overflow = 1'b1;
    send(32'h0007_0000);
    clr_overflow = 1'b0;
    check("ovf_set_beats_clr", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    out_ready = 1'b1;
    tick();
    check("ovf_clear2", 32'(overflow), 32'd0);

    // 4: stop with a pending word drains first
    out_ready = 1'b0;
    push_exp(16'h0005);
    send(32'h0005_0000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_mic_off", 32'(mic_clk_en), 32'd0);
    check("drain_flush", 32'(dec_flush), 32'd1);
    repeat (3) tick();
    send(32'h0008_0000);
    check("drain_ignores_in", 32'(overflow), 32'd0);
    check("drain_still_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_done_idle", 32'(busy), 32'd0);
    check("drain_done_valid", 32'(out_valid), 32'd0);

    // 5: stop during SETTLE, start during RUN, async reset mid-RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (WAKE_CYCLES) tick();
    send(32'h0001_0000);
    send(32'h0002_0000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("settle_stop_idle", 32'(busy), 32'd0);
    check("settle_stop_flush", 32'(dec_flush), 32'd1);
    check("settle_stop_novalid", 32'(out_valid), 32'd0);
    enter_run();
    send(32'h0009_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_run_busy", 32'(busy), 32'd1);
    check("start_in_run_flush", 32'(dec_flush), 32'd0);
    check("start_in_run_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_flush", 32'(dec_flush), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

`ifdef PDM_CAPTURE_CTRL_DC_BLOCK_EN
    // 6: constant input decays through the DC block
    enter_run();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      push_exp(16'h0100);
      send(32'h0100_0000);
    end
    tick();
    tick();
    check("dc_decayed", 32'(($signed(last_out) < 16'sd16) && ($signed(last_out) > -16'sd16)), 32'd1);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pdm_capture_ctrl.md
Name: pdm_capture_ctrl

Overview:
Capture sequencer between the PDM mic front end (clock generator plus CIC decimator) and the equalizer input. It enables the mic clock and waits out mic wake-up time. It holds the decimator in flush, then discards CIC start-up transients. In run, each decimated sample is scaled and saturated to PCM width and handed downstream over a valid/ready handshake, with sticky overflow detection because the decimator cannot be back-pressured.

Parameters:
IN_W, 32, decimator sample width (signed)
PCM_W, 16, output PCM width (signed)
SHIFT, 16, arithmetic right shift applied before saturation; 0 <= SHIFT < IN_W
WAKE_CYCLES, 1_000_000, clk cycles of mic wake-up (10 ms at 100 MHz); >= 1
SETTLE_SAMPLES, 8, decimator outputs discarded after flush release; >= 1
DC_K, 10, DC-block pole shift (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle capture start request
stop  in  1  single-cycle capture stop request
mic_clk_en  out  1  enable to the PDM clock generator
dec_flush  out  1  synchronous clear to the decimator
pcm_in_data  in  IN_W  decimator sample, signed
pcm_in_valid  in  1  single-cycle sample strobe, no backpressure
out_data  out  PCM_W  PCM sample to equalizer, signed
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept
busy  out  1  state != IDLE
overflow  out  1  sticky: sample dropped
clr_overflow  in  1  clears overflow

Behaviour:
- Reset values (async): state IDLE; mic_clk_en 0, dec_flush 1, out_valid 0, out_data 0, overflow 0, busy 0, all counters 0.
- FSM states: IDLE, WAKE, SETTLE, RUN, DRAIN.
- IDLE: mic_clk_en=0, dec_flush=1. start -> WAKE next cycle, wake counter loaded 0.
- WAKE: mic_clk_en=1, dec_flush=1. Counter increments each cycle. On the cycle the count reaches WAKE_CYCLES-1 -> SETTLE, so WAKE lasts exactly WAKE_CYCLES cycles.
- SETTLE: mic_clk_en=1, dec_flush=0. Each pcm_in_valid is discarded and counted. The SETTLE_SAMPLES-th valid is also discarded -> RUN.
- RUN: mic_clk_en=1, dec_flush=0.
  - Each pcm_in_valid loads the output register; out_valid rises the following cycle (latency 1).
  - Scaling: t = pcm_in_data >>> SHIFT (signed). Saturate to [-2^(PCM_W-1), 2^(PCM_W-1)-1].
- Output handshake:
  - out_data/out_valid are held stable until out_valid && out_ready.
  - If pcm_in_valid arrives while out_valid && !out_ready: the new sample is dropped, the held sample is retained, and overflow is set.
  - If out_ready is high in the same cycle as pcm_in_valid: the held sample is accepted, the new one is loaded, and overflow is not set.
- stop:
  - In WAKE or SETTLE: -> IDLE next cycle.
  - In RUN: -> DRAIN if out_valid is pending and not accepted that cycle, else -> IDLE.
  - In IDLE: ignored.
- DRAIN: mic_clk_en=0, dec_flush=1, inputs ignored (no overflow). On out_valid && out_ready -> IDLE.
- start outside IDLE is ignored. start and stop in the same cycle in IDLE: no action.
- overflow: set has priority over clr_overflow in the same cycle.
- Async reset mid-capture: immediate return to reset values. Any pending sample is lost.

Optional Feature:
Macro PDM_CAPTURE_CTRL_DC_BLOCK_EN.
- Defined: a DC-block stage is inserted after saturation in RUN: y = x - x_prev + y_prev - (y_prev >>> DC_K).
  - Computed at PCM_W+DC_K+2 bits and saturated to PCM_W.
  - x_prev/y_prev update only on accepted-into-register samples. They clear to 0 on entering RUN and on reset.
  - Latency is still 1 cycle (single registered stage).
- Undefined: out_data is the saturated value directly. No extra state is instantiated.

Decomposition:
- Package pdm_capture_pkg holds: state enum typedef (IDLE, WAKE, SETTLE, RUN, DRAIN) and localparam saturation limits as functions of PCM_W.
- Natural sub-module pdm_sat_scale: combinational shift-and-saturate (IN_W->PCM_W), reused by the DC-block path.

Test Plan:
1. WAKE_CYCLES=20, SETTLE_SAMPLES=4. Pulse start.
   -> mic_clk_en rises next cycle; dec_flush falls exactly 20 cycles later.
   -> First 4 pcm_in_valid produce no out_valid; the 5th produces out_valid one cycle later.
2. RUN, SHIFT=16, PCM_W=16, out_ready=1. Inputs 0x0001_2345, 0x8000_0000, 0x7FFF_FFFF, 0xFFFF_0000.
   -> out_data 0x0001, 0x8000, 0x7FFF, 0xFFFF.
   Input 0x0000_FFFF -> 0x0000.
3. RUN, out_ready=0, two valids 0x0003_0000 then 0x0004_0000.
   -> out_data holds 0x0003, overflow=1.
   clr_overflow alone -> overflow=0.
   Repeat with out_ready=1 coincident with the 2nd valid -> no overflow, out_data 0x0004.
4. RUN with pending out_valid and out_ready=0, pulse stop.
   -> DRAIN, mic_clk_en=0, busy=1 until out_ready pulse.
   -> IDLE next cycle, busy=0.
5. Stop during SETTLE -> IDLE next cycle, no out_valid.
   Start during RUN -> no state change.
   Assert rst mid-RUN with out_valid=1 -> out_valid=0 and dec_flush=1 immediately.
6. With PDM_CAPTURE_CTRL_DC_BLOCK_EN, DC_K=4, constant input 0x0100_0000, SHIFT=16.
   -> first output 0x0100, then monotonically decaying toward 0 (|out_data| < 0x0010 within 64 samples).
